// File: rtl/puvvada_says_btn_decoder.sv
// Debounces the four board direction buttons into single colour events held under valid/ack.
// Define BTN_EVENT_ON_RELEASE_EN to fire the event when the release debounce completes.
module puvvada_says_btn_decoder #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned CNT_W           = 20
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       ON,
    input  logic       Btn_U,
    input  logic       Btn_R,
    input  logic       Btn_D,
    input  logic       Btn_L,
    output logic [1:0] Color,
    output logic       Color_Valid,
    input  logic       Color_Ack,
    output logic       Overrun,
    output logic       Busy
);

    typedef enum logic [1:0] {StIdle, StDebPress, StHeld, StDebRelease} state_e;

    localparam logic [CNT_W-1:0] CntMax = CNT_W'(DEBOUNCE_CYCLES - 1);

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [1:0]       sel_q;
    logic [3:0]       btn_raw;
    logic [3:0]       sync_q1;
    logic [3:0]       sync_q2;

    logic       one_hot;
    logic [1:0] enc;
    logic       s_sel;
    logic       others_hi;
    logic       cnt_done;
    logic       evt;

    // Bit index equals the colour code: U=0, R=1, D=2, L=3.
    assign btn_raw = {Btn_L, Btn_D, Btn_R, Btn_U};

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            sync_q1 <= 4'b0000;
            sync_q2 <= 4'b0000;
        end else begin
            sync_q1 <= btn_raw;
            sync_q2 <= sync_q1;
        end
    end

    always_comb begin
        one_hot = 1'b1;
        enc     = 2'd0;
        unique case (sync_q2)
            4'b0001: enc = 2'd0;
            4'b0010: enc = 2'd1;
            4'b0100: enc = 2'd2;
            4'b1000: enc = 2'd3;
            default: one_hot = 1'b0;
        endcase
    end

    assign s_sel     = sync_q2[sel_q];
    assign others_hi = |(sync_q2 & ~(4'b0001 << sel_q));
    assign cnt_done  = (cnt_q == CntMax);

`ifdef BTN_EVENT_ON_RELEASE_EN
    assign evt = ON && (state_q == StDebRelease) && !s_sel && cnt_done;
`else
    assign evt = ON && (state_q == StDebPress) && s_sel && !others_hi && cnt_done;
`endif

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            sel_q       <= 2'd0;
            Busy        <= 1'b0;
            Color       <= 2'd0;
            Color_Valid <= 1'b0;
            Overrun     <= 1'b0;
        end else begin
            if (!ON) begin
                state_q <= StIdle;
                cnt_q   <= '0;
                Busy    <= 1'b0;
            end else begin
                case (state_q)
                    StIdle: begin
                        cnt_q <= '0;
                        if (one_hot) begin
                            sel_q   <= enc;
                            state_q <= StDebPress;
                            Busy    <= 1'b1;
                        end
                    end
                    StDebPress: begin
                        if (!s_sel || others_hi) begin
                            state_q <= StIdle;
                            cnt_q   <= '0;
                            Busy    <= 1'b0;
                        end else if (cnt_done) begin
                            state_q <= StHeld;
                            cnt_q   <= '0;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    StHeld: begin
                        cnt_q <= '0;
                        if (!s_sel) begin
                            state_q <= StDebRelease;
                        end
                    end
                    StDebRelease: begin
                        if (s_sel) begin
                            state_q <= StHeld;
                            cnt_q   <= '0;
                        end else if (cnt_done) begin
                            state_q <= StIdle;
                            cnt_q   <= '0;
                            Busy    <= 1'b0;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    default: begin
                        state_q <= StIdle;
                        cnt_q   <= '0;
                        Busy    <= 1'b0;
                    end
                endcase
            end

            // A simultaneous ack consumes the old event, so the new one is not an overrun.
            if (evt) begin
                Color       <= sel_q;
                Color_Valid <= 1'b1;
                if (Color_Valid && !Color_Ack) begin
                    Overrun <= 1'b1;
                end
            end else if (Color_Valid && Color_Ack) begin
                Color_Valid <= 1'b0;
            end
        end
    end

endmodule

// File: doc/puvvada_says_btn_decoder.md
# puvvada_says_btn_decoder

Input-side companion to the level display path of the Simon game: converts the four raw board direction buttons into clean, debounced, single-event colour codes for `puvvada_says_sm`. The block sits between the board pins (BtnU/BtnR/BtnD/BtnL) and the game state machine. It holds each decoded colour under a valid/ack handshake, so a slow consumer never loses or double-counts a press.

## Interface
- `DEBOUNCE_CYCLES`, default 500000: consecutive stable samples required to accept a press or release (5 ms at 100 MHz).
- `CNT_W`, default 20: debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.
- `Clk`  in  1  system clock; all logic is on the rising edge.
- `Reset`  in  1  asynchronous, active-low reset.
- `ON`  in  1  enable; low forces the FSM to IDLE and suppresses events.
- `Btn_U`, `Btn_R`, `Btn_D`, `Btn_L`  in  1 each  raw, asynchronous, active-high buttons.
- `Color`  out  2  decoded colour: U=0, R=1, D=2, L=3.
- `Color_Valid`  out  1  `Color` holds an unconsumed event.
- `Color_Ack`  in  1  consumer accepts the event.
- `Overrun`  out  1  sticky; an event arrived while `Color_Valid` was high and no ack was given.
- `Busy`  out  1  high in any FSM state other than IDLE.

## Operation
- Each button passes through a 2-FF synchronizer. The FSM sees only synchronized values (`s_U`..`s_L`).
- One shared FSM with a shared counter and a latched 2-bit `sel`:
  - IDLE: counter=0. Exactly one `s_*` high → latch `sel`, go to DEB_PRESS. Zero or two or more high → stay in IDLE; chords are ignored.
  - DEB_PRESS: counter increments each cycle.
    - `s_sel` falls, or any other button rises → IDLE, no event.
    - Counter reaches DEBOUNCE_CYCLES-1 with `s_sel` still high → HELD; the press event fires.
  - HELD: counter=0. `s_sel` falls → DEB_RELEASE. Other buttons are ignored.
  - DEB_RELEASE: counter increments while `s_sel` is low.
    - `s_sel` reasserts → HELD, no new event.
    - Counter reaches DEBOUNCE_CYCLES-1 → IDLE.
- Event load: `Color`←`sel`, `Color_Valid`←1.
  - If `Color_Valid` was already 1 with no ack in the same cycle, the old `Color` is overwritten and `Overrun`←1.
- Ack: `Color_Ack`=1 while `Color_Valid`=1 clears `Color_Valid` next cycle.
  - Ack and a new event in the same cycle: the new event loads, `Color_Valid` stays 1, no overrun.
  - Ack while `Color_Valid`=0 is ignored.
- `ON`=0 behaves as a synchronous clear of FSM and counter only. `Color`, `Color_Valid` and `Overrun` keep their values.
- `Overrun` clears only on reset.

## Timing
- Reset values: `Color`=0, `Color_Valid`=0, `Overrun`=0, `Busy`=0, FSM=IDLE, counter=0, synchronizers=0.
- Press latency: raw button sampled high at edge k gives `Color_Valid` high after edge k+2+DEBOUNCE_CYCLES, with the button stable throughout.
  - 2 cycles of synchronizer, 1 cycle IDLE→DEB_PRESS, then DEBOUNCE_CYCLES-1 cycles of counting, then the event register.
- Release: from the first low synchronized sample, DEBOUNCE_CYCLES cycles until IDLE. Only then is a new press accepted.
- One event per accepted press. A glitch shorter than DEBOUNCE_CYCLES produces no event.
- `Color_Valid` falls exactly 1 cycle after the ack edge.
- Reset asserted mid-operation: all outputs return to reset values immediately (asynchronously). A pending event is lost.

## Configuration
- `BTN_EVENT_ON_RELEASE_EN`
  - Defined: no event on DEB_PRESS→HELD. The event fires on DEB_RELEASE→IDLE completion and carries the latched `sel`.
  - Undefined (default): the event fires on press, as described above.
- All other behaviour is identical in both builds.

## Test plan
Bench uses `DEBOUNCE_CYCLES`=4 and `ON`=1 unless stated.
- Reset then clean press: hold `Btn_R` for 20 cycles → `Color`=1 and `Color_Valid`=1 exactly 6 cycles after the first high sample; exactly one event; `Busy` high until 4 cycles after release is synchronized.
- Bounce: `Btn_L` high 2 cycles, low 1, high 10 → one event with `Color`=3, only after the final stable run.
- Chord: `Btn_U` and `Btn_D` rise in the same cycle and are held 10 cycles → no event; `Busy` stays 0.
- Overrun and ack collision:
  - Press U with no ack, then press D → `Color`=2, `Overrun`=1.
  - Press R with ack asserted in the event-load cycle → `Color`=1, `Color_Valid`=1, `Overrun` unchanged.
- Mid-operation:
  - Drop `ON` during DEB_PRESS → FSM returns to IDLE, no event.
  - Assert `Reset`=0 while `Color_Valid`=1 → all outputs 0 in the same cycle.
- `BTN_EVENT_ON_RELEASE_EN` build: press U for 10 cycles, then release → `Color_Valid` rises 4 cycles after release is synchronized; nothing during the hold.
